// File: rtl/ps2_mouse_packet_engine.sv
// ps2_mouse_packet_engine
//   Packet layer behind the PS/2 byte receiver. Assembles 3-byte (standard) or
//   4-byte (wheel) mouse packets, keeps a clamped absolute X/Y pointer position,
//   a wrapping wheel accumulator and the button/overflow status. Drops partial
//   packets on receive errors, lost header sync, inter-byte timeout or when
//   streaming is disabled.
// Ports
//   CLK, RESET          clock, asynchronous active-low reset
//   STREAM_EN           mouse initialised; when low all bytes are ignored
//   WHEEL_MODE          1: 4-byte packets, 0: 3-byte packets (sampled at header)
//   BYTE_IN/VALID/ERROR received byte, 1-cycle strobe, nonzero error = bad byte
//   MOUSE_X/Y/Z         absolute position and wheel accumulator
//   MOUSE_STATUS        {L, R, M, X|Y overflow} of the last committed packet
//   SEND_INTERRUPT      1-cycle pulse when a packet is committed
//   PKT_ERR             1-cycle pulse when a packet (or stray byte) is discarded
//   current_state       debug view of the packet FSM
module ps2_mouse_packet_engine #(
    parameter int X_W         = 8,
    parameter int Y_W         = 8,
    parameter int Z_W         = 8,
    parameter int LIMIT_X     = 160,
    parameter int LIMIT_Y     = 120,
    parameter int INVERT_Y    = 1,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           STREAM_EN,
    input  logic           WHEEL_MODE,
    input  logic [7:0]     BYTE_IN,
    input  logic           BYTE_VALID,
    input  logic [1:0]     BYTE_ERROR,
    output logic [X_W-1:0] MOUSE_X,
    output logic [Y_W-1:0] MOUSE_Y,
    output logic [Z_W-1:0] MOUSE_Z,
    output logic [3:0]     MOUSE_STATUS,
    output logic           SEND_INTERRUPT,
    output logic           PKT_ERR,
    output logic [7:0]     current_state
);

    // Signed working widths leave headroom for a 9-bit delta and the sign.
    localparam int XS = ((X_W > 9) ? X_W : 9) + 2;
    localparam int YS = ((Y_W > 9) ? Y_W : 9) + 2;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic signed [XS-1:0] X_MAX = XS'(LIMIT_X - 1);
    localparam logic signed [YS-1:0] Y_MAX = YS'(LIMIT_Y - 1);

    if (LIMIT_X > (2 ** X_W) || LIMIT_X < 1) begin : g_bad_limit_x
        $error("LIMIT_X does not fit in X_W bits");
    end
    if (LIMIT_Y > (2 ** Y_W) || LIMIT_Y < 1) begin : g_bad_limit_y
        $error("LIMIT_Y does not fit in Y_W bits");
    end

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2,
        B3 = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  cnt_q, cnt_d;
    logic [7:0]     hdr_q, hdr_d;
    logic [7:0]     dx_q, dx_d;
    logic [7:0]     dy_q, dy_d;
    logic           wm_q, wm_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [Z_W-1:0] z_q, z_d;
    logic [3:0]     st_q, st_d;
    logic           int_q, int_d;
    logic           err_q, err_d;

    logic signed [8:0]    dx_s, dy_s;
    logic [7:0]           dy_src_s;
    logic signed [XS-1:0] x_sum_s;
    logic signed [YS-1:0] y_sum_s;
    logic [X_W-1:0]       x_new_s;
    logic [Y_W-1:0]       y_new_s;
    logic [Z_W-1:0]       z_new_s;
    logic                 good_s, bad_s, tmo_s, commit_s;
    state_t               eff_state_s;

    // Candidate position/wheel values for a commit happening this cycle.
    always_comb begin
        // In B2 the dy byte is on BYTE_IN right now; in B3 it was latched earlier.
        dy_src_s = (state_q == B2) ? BYTE_IN : dy_q;
        // An overflow flag saturates the delta to the extreme of its sign.
        if (hdr_q[6]) begin
            dx_s = hdr_q[4] ? 9'h100 : 9'h0FF;
        end else begin
            dx_s = {hdr_q[4], dx_q};
        end
        if (hdr_q[7]) begin
            dy_s = hdr_q[5] ? 9'h100 : 9'h0FF;
        end else begin
            dy_s = {hdr_q[5], dy_src_s};
        end
        x_sum_s = $signed(XS'(x_q)) + XS'(dx_s);
        if (INVERT_Y != 0) begin
            y_sum_s = $signed(YS'(y_q)) - YS'(dy_s);
        end else begin
            y_sum_s = $signed(YS'(y_q)) + YS'(dy_s);
        end
        if (x_sum_s[XS-1]) begin
            x_new_s = '0;
        end else if (x_sum_s > X_MAX) begin
            x_new_s = X_MAX[X_W-1:0];
        end else begin
            x_new_s = x_sum_s[X_W-1:0];
        end
        if (y_sum_s[YS-1]) begin
            y_new_s = '0;
        end else if (y_sum_s > Y_MAX) begin
            y_new_s = Y_MAX[Y_W-1:0];
        end else begin
            y_new_s = y_sum_s[Y_W-1:0];
        end
        z_new_s = z_q + Z_W'($signed(BYTE_IN[3:0]));
    end

    // Packet FSM: next state, byte latches, commit and pulse generation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hdr_d    = hdr_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        wm_d     = wm_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        st_d     = st_q;
        int_d    = 1'b0;
        err_d    = 1'b0;
        commit_s = 1'b0;
        good_s   = BYTE_VALID && (BYTE_ERROR == 2'b00);
        bad_s    = BYTE_VALID && (BYTE_ERROR != 2'b00);
        tmo_s    = (state_q != B0) && (cnt_q == TW'(TIMEOUT_CYC));
        // A timeout abandons the packet; a byte in that cycle is seen as a header.
        eff_state_s = tmo_s ? B0 : state_q;

        if (!STREAM_EN) begin
            state_d = B0;
            cnt_d   = '0;
        end else begin
            if (tmo_s) begin
                err_d = 1'b1;
            end else begin
                err_d = 1'b0;
            end
            case (eff_state_s)
                B0: begin
                    cnt_d   = '0;
                    state_d = B0;
                    if (bad_s || (good_s && !BYTE_IN[3])) begin
                        err_d = 1'b1;
                    end else if (good_s) begin
                        hdr_d   = BYTE_IN;
                        wm_d    = WHEEL_MODE;
                        state_d = B1;
                    end else begin
                        state_d = B0;
                    end
                end
                B1: begin
                    if (bad_s) begin
                        err_d   = 1'b1;
                        state_d = B0;
                    end else if (good_s) begin
                        dx_d    = BYTE_IN;
                        cnt_d   = '0;
                        state_d = B2;
                    end else begin
                        cnt_d = cnt_q + TW'(1);
                    end
                end
                B2: begin
                    if (bad_s) begin
                        err_d   = 1'b1;
                        state_d = B0;
                    end else if (good_s) begin
                        dy_d  = BYTE_IN;
                        cnt_d = '0;
                        if (wm_q) begin
                            state_d = B3;
                        end else begin
                            commit_s = 1'b1;
                            state_d  = B0;
                        end
                    end else begin
                        cnt_d = cnt_q + TW'(1);
                    end
                end
                B3: begin
                    if (bad_s) begin
                        err_d   = 1'b1;
                        state_d = B0;
                    end else if (good_s) begin
                        cnt_d    = '0;
                        commit_s = 1'b1;
                        state_d  = B0;
                    end else begin
                        cnt_d = cnt_q + TW'(1);
                    end
                end
                default: begin
                    state_d = B0;
                    cnt_d   = '0;
                end
            endcase
            if (commit_s) begin
                x_d   = x_new_s;
                y_d   = y_new_s;
                z_d   = wm_q ? z_new_s : z_q;
                st_d  = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[6] | hdr_q[7]};
                int_d = 1'b1;
            end else begin
                int_d = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= B0;
            cnt_q   <= '0;
            hdr_q   <= 8'h00;
            dx_q    <= 8'h00;
            dy_q    <= 8'h00;
            wm_q    <= 1'b0;
            x_q     <= X_W'(LIMIT_X / 2);
            y_q     <= Y_W'(LIMIT_Y / 2);
            z_q     <= '0;
            st_q    <= 4'h0;
            int_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            wm_q    <= wm_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            st_q    <= st_d;
            int_q   <= int_d;
            err_q   <= err_d;
        end
    end

    assign MOUSE_X        = x_q;
    assign MOUSE_Y        = y_q;
    assign MOUSE_Z        = z_q;
    assign MOUSE_STATUS   = st_q;
    assign SEND_INTERRUPT = int_q;
    assign PKT_ERR        = err_q;
    assign current_state  = {6'b000000, state_q};

endmodule
